// File: rtl/debounce_pkg.sv
// Shared helpers for the push-button conditioner: constant width functions
// used to size the prescaler, stability and repeat counters.
package debounce_pkg;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width for a counter that must hold values 0..n-1, never below 1 bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Larger of two integers.
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MIN_CNT_W = 1;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, tick-sampled stability filter
// and hold-to-auto-repeat counter. The sample strobe comes from the shared
// prescaler in the top level.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE     = 3,
    parameter int REPEAT_DLY = 16,
    parameter int REPEAT_PER = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic TICK,
    input  logic BTN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL,
    output logic PRESS
);

    localparam int SW = cnt_w(STABLE);
    localparam int RW = cnt_w(imax(REPEAT_DLY, REPEAT_PER) + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE - 1);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);
    localparam logic [RW-1:0] REP_DLY   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] REP_PER   = RW'(REPEAT_PER);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);
    localparam logic          REP_EN    = (REPEAT_DLY > 0);

    logic          sync_p0;
    logic          sync_p1;
    logic [SW-1:0] stab;
    logic [RW-1:0] rep;
    logic          differ;
    logic          accept;
    logic          rise_evt;
    logic          fall_evt;
    logic          rep_evt;

    // Decode this edge's filter and repeat events from the synchronised sample.
    always_comb begin
        differ   = (sync_p1 != LEVEL);
        accept   = TICK & differ & (stab == STAB_LAST);
        rise_evt = accept & sync_p1;
        fall_evt = accept & ~sync_p1;
        rep_evt  = REP_EN & TICK & LEVEL & ~accept & (rep == REP_ONE);
    end

    // Stage p0/p1: metastability synchroniser, clocked every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= BTN;
            sync_p1 <= sync_p0;
        end
    end

    // Stability filter: any agreeing sample restarts the count of differing ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stab  <= '0;
            LEVEL <= 1'b0;
        end else if (TICK) begin
            if (!differ) begin
                stab <= '0;
            end else if (accept) begin
                stab  <= '0;
                LEVEL <= sync_p1;
            end else begin
                stab <= stab + STAB_ONE;
            end
        end
    end

    // Registered one-cycle event pulses; PRESS merges the press with repeats.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RISE  <= 1'b0;
            FALL  <= 1'b0;
            PRESS <= 1'b0;
        end else begin
            RISE  <= rise_evt;
            FALL  <= fall_evt;
            PRESS <= rise_evt | rep_evt;
        end
    end

    // Auto-repeat countdown, armed on an accepted press and idle while released.
    always_ff @(posedge CLK) begin
        if (RST || !REP_EN) begin
            rep <= '0;
        end else if (rise_evt) begin
            rep <= REP_DLY;
        end else if (fall_evt || !LEVEL) begin
            rep <= '0;
        end else if (TICK && !accept) begin
            if (rep == REP_ONE) begin
                rep <= REP_PER;
            end else if (rep > REP_ONE) begin
                rep <= rep - REP_ONE;
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: one shared sample prescaler feeding
// NCH independent debounce channels.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIV        = 2500000,
    parameter int STABLE     = 3,
    parameter int REPEAT_DLY = 16,
    parameter int REPEAT_PER = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] BTNIN,
    output logic [NCH-1:0] LEVEL,
    output logic [NCH-1:0] RISE,
    output logic [NCH-1:0] FALL,
    output logic [NCH-1:0] PRESS,
    output logic           TICK
);

    localparam int PW = cnt_w(DIV);
    localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);

    logic [PW-1:0] cnt;

    assign TICK = (cnt == CNT_LAST);

    // Free-running prescaler wrapping at DIV-1; TICK marks its last count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .STABLE    (STABLE),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_chan (
            .CLK  (CLK),
            .RST  (RST),
            .TICK (TICK),
            .BTN  (BTNIN[i]),
            .LEVEL(LEVEL[i]),
            .RISE (RISE[i]),
            .FALL (FALL[i]),
            .PRESS(PRESS[i])
        );
    end

endmodule
